// File: rtl/cnn_if_pkg.sv
// Shared constants and types for the CNN frame driver.
// Holds the frame geometry, the driver state encoding and the timeout result word.
package cnn_if_pkg;

  localparam int unsigned PIX_W       = 8;
  localparam int unsigned N_PIX       = 144;
  localparam int unsigned IMG_W       = PIX_W * N_PIX;
  localparam int unsigned PRED_W      = 32;
  localparam int unsigned TIMEOUT_CYC = 4096;
  localparam int unsigned CNT_W       = $clog2(N_PIX);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam logic [PRED_W-1:0] PRED_TIMEOUT = '1;

endpackage

// File: rtl/cnn_img_packer.sv
// Packs accepted pixel beats into the flat image register, pixel 0 at the LSBs.
// Frames are delimited by beat count; a disagreeing s_last only raises err_frame.
module cnn_img_packer
  import cnn_if_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_i,
  input  logic [PIX_W-1:0] s_data_i,
  input  logic             s_last_i,
  output logic [IMG_W-1:0] img_o,
  output logic             last_beat_c,
  output logic             err_frame_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic             err_q, err_d;
  logic             is_last;

  assign is_last     = (cnt_q == CNT_W'(N_PIX - 1));
  assign last_beat_c = accept_i && is_last;

  always_comb begin
    cnt_d = cnt_q;
    img_d = img_q;
    err_d = 1'b0;
    if (accept_i) begin
      cnt_d = is_last ? '0 : cnt_q + CNT_W'(1);
      err_d = (s_last_i != is_last);
      for (int unsigned i = 0; i < N_PIX; i++) begin
        if (cnt_q == CNT_W'(i)) img_d[i*PIX_W +: PIX_W] = s_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      img_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      img_q <= img_d;
      err_q <= err_d;
    end
  end

  assign img_o       = img_q;
  assign err_frame_o = err_q;

endmodule

// File: rtl/cnn_frame_driver.sv
// Host-side initiator for the CNN pipeline: loads a frame, strobes start,
// waits (bounded) for done, and hands the captured prediction to the sink.
module cnn_frame_driver #(
  parameter int unsigned TIMEOUT_CYC = cnn_if_pkg::TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [cnn_if_pkg::PIX_W-1:0]  s_data,
  input  logic                          s_last,
  output logic [cnn_if_pkg::IMG_W-1:0]  cnn_img,
  output logic                          cnn_valid,
  input  logic                          cnn_ready,
  input  logic [cnn_if_pkg::PRED_W-1:0] cnn_predict,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [cnn_if_pkg::PRED_W-1:0] res_data,
  output logic                          err_frame,
  output logic                          err_timeout
);

  import cnn_if_pkg::*;

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [PRED_W-1:0]   res_q, res_d;
  logic                s_ready_q, s_ready_d;
  logic                cnn_valid_q, cnn_valid_d;
  logic                res_valid_q, res_valid_d;
  logic                err_to_q, err_to_d;
  logic                accept;
  logic                last_beat;

  // s_ready_q is only ever high while in LOAD, so it alone qualifies a beat
  assign accept = s_valid && s_ready_q;

  cnn_img_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
    .s_data_i    (s_data),
    .s_last_i    (s_last),
    .img_o       (cnn_img),
    .last_beat_c (last_beat),
    .err_frame_o (err_frame)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    res_d    = res_q;
    err_to_d = 1'b0;
    unique case (state_q)
      LOAD:  if (last_beat) state_d = START;
      START: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        // done on the final wait cycle still beats the timeout
        if (cnn_ready) begin
          res_d   = cnn_predict;
          state_d = OUT;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 2)) begin
          res_d    = PRED_TIMEOUT;
          err_to_d = 1'b1;
          state_d  = OUT;
        end
      end
      OUT:     if (res_valid_q && res_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
    s_ready_d   = (state_d == LOAD);
    cnn_valid_d = (state_d == START);
    res_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      wait_q      <= '0;
      res_q       <= '0;
      s_ready_q   <= 1'b0;
      cnn_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      res_q       <= res_d;
      s_ready_q   <= s_ready_d;
      cnn_valid_q <= cnn_valid_d;
      res_valid_q <= res_valid_d;
      err_to_q    <= err_to_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign cnn_valid   = cnn_valid_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_q;
  assign err_timeout = err_to_q;

endmodule
